// File: rtl/maxnet_engine.sv
// Winner-take-all (Maxnet) engine: captures N activations, iterates lateral
// inhibition with all channels in parallel, and reports the surviving channel.
module maxnet_engine #(
  parameter int N        = 4,
  parameter int W        = 32,
  parameter int EPS_W    = 16,
  parameter int MAX_ITER = 255,
  parameter int IW       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N*W-1:0]       x_in,
  input  logic [EPS_W-1:0]     eps,
  output logic                 busy,
  output logic                 done,
  output logic                 winner_valid,
  output logic                 timeout,
  output logic [$clog2(N)-1:0] winner_idx,
  output logic [W-1:0]         winner_val,
  output logic [IW-1:0]        iter_count
);

  localparam int IDX_W  = $clog2(N);
  localparam int SUM_W  = W + IDX_W;
  localparam int PROD_W = SUM_W + EPS_W;
  localparam int CNT_W  = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [W-1:0]     x_reg [N];
  logic [W-1:0]     a_reg [N];
  logic [W-1:0]     a_next [N];
  logic [EPS_W-1:0] eps_reg;
  logic [IW-1:0]    iter;

  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  nz_cnt;
  logic [IDX_W-1:0]  nz_idx;
  logic [IDX_W-1:0]  max_idx;
  logic [W-1:0]      max_val;
  logic [IDX_W-1:0]  result_idx;
  logic              terminate;

  logic [SUM_W-1:0]  rem;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] pen;

  // Strict greater-than keeps the lowest index when activations are equal.
  always_comb begin
    sum     = '0;
    nz_cnt  = '0;
    nz_idx  = '0;
    max_idx = '0;
    max_val = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + SUM_W'(a_reg[i]);
      if (a_reg[i] != '0) begin
        nz_cnt = nz_cnt + CNT_W'(1);
        nz_idx = IDX_W'(i);
      end
      if (a_reg[i] > max_val) begin
        max_val = a_reg[i];
        max_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    terminate = (nz_cnt <= CNT_W'(1)) || (iter == IW'(MAX_ITER));
    if (nz_cnt == CNT_W'(1)) begin
      result_idx = nz_idx;
    end else if (nz_cnt == '0) begin
      result_idx = '0;
    end else begin
      result_idx = max_idx;
    end
  end

  // Ceiling of the scaled penalty guarantees progress whenever eps and the rest-sum are nonzero.
  always_comb begin
    rem  = '0;
    prod = '0;
    pen  = '0;
    for (int i = 0; i < N; i++) begin
      rem       = sum - SUM_W'(a_reg[i]);
      prod      = PROD_W'(rem) * PROD_W'(eps_reg);
      pen       = (prod >> EPS_W) + PROD_W'(|prod[EPS_W-1:0]);
      a_next[i] = (pen >= PROD_W'(a_reg[i])) ? '0 : a_reg[i] - pen[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (terminate) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  // Results are captured on the RUN->DONE transition and held until the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        x_reg[i] <= '0;
        a_reg[i] <= '0;
      end
      eps_reg      <= '0;
      iter         <= '0;
      winner_valid <= 1'b0;
      timeout      <= 1'b0;
      winner_idx   <= '0;
      winner_val   <= '0;
      iter_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N; i++) begin
              x_reg[i] <= x_in[i*W +: W];
              a_reg[i] <= x_in[i*W +: W];
            end
            eps_reg      <= eps;
            iter         <= '0;
            winner_valid <= 1'b0;
            timeout      <= 1'b0;
            winner_idx   <= '0;
            winner_val   <= '0;
            iter_count   <= '0;
          end
        end
        RUN: begin
          if (terminate) begin
            winner_valid <= (nz_cnt == CNT_W'(1));
            timeout      <= (nz_cnt > CNT_W'(1));
            winner_idx   <= result_idx;
            winner_val   <= x_reg[result_idx];
            iter_count   <= iter;
          end else begin
            for (int i = 0; i < N; i++) begin
              a_reg[i] <= a_next[i];
            end
            iter <= iter + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_engine.sv
// Self-checking bench for maxnet_engine: directed cases plus randomized runs
// compared against a behavioural Maxnet model.
module tb_maxnet_engine;

  localparam int N        = 4;
  localparam int W        = 32;
  localparam int EPS_W    = 16;
  localparam int MAX_ITER = 255;
  localparam int IW       = 8;
  localparam int BOUND    = 400;

  typedef struct {
    logic          valid;
    logic          tmo;
    logic [1:0]    idx;
    logic [W-1:0]  val;
    logic [IW-1:0] iter;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [N*W-1:0]   x_in = '0;
  logic [EPS_W-1:0] eps = '0;
  logic             busy, done, winner_valid, timeout;
  logic [1:0]       winner_idx;
  logic [W-1:0]     winner_val;
  logic [IW-1:0]    iter_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maxnet_engine #(.N(N), .W(W), .EPS_W(EPS_W), .MAX_ITER(MAX_ITER), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .eps(eps),
    .busy(busy), .done(done), .winner_valid(winner_valid), .timeout(timeout),
    .winner_idx(winner_idx), .winner_val(winner_val), .iter_count(iter_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: iterate the inhibition rule on plain integers until a termination rule fires.
  task automatic model(input logic [W-1:0] xv [N], input logic [EPS_W-1:0] e, output res_t r);
    longint unsigned a [N];
    longint unsigned s, rr, p, best;
    int nz, last, k;
    bit fin;
    for (int i = 0; i < N; i++) a[i] = longint'(xv[i]);
    k = 0;
    fin = 0;
    r.valid = 0; r.tmo = 0; r.idx = 0;
    while (!fin) begin
      nz = 0; last = 0;
      for (int i = 0; i < N; i++) if (a[i] != 0) begin nz++; last = i; end
      if (nz == 1) begin
        r.valid = 1; r.idx = 2'(last); fin = 1;
      end else if (nz == 0) begin
        fin = 1;
      end else if (k == MAX_ITER) begin
        r.tmo = 1; best = 0;
        for (int i = 0; i < N; i++) if (a[i] > best) begin best = a[i]; r.idx = 2'(i); end
        fin = 1;
      end else begin
        s = 0;
        for (int i = 0; i < N; i++) s += a[i];
        for (int i = 0; i < N; i++) begin
          rr = s - a[i];
          p = (rr * longint'(e) + 64'd65535) / 64'd65536;
          a[i] = (p >= a[i]) ? 0 : a[i] - p;
        end
        k++;
      end
    end
    r.val = xv[r.idx];
    r.iter = IW'(k);
  endtask

  // Launch one run; optionally pulse start with junk data at wait cycle pulse_at.
  task automatic applyStimulus(input logic [W-1:0] xv [N], input logic [EPS_W-1:0] e,
                               input int pulse_at, output int cycles);
    @(negedge clk);
    for (int i = 0; i < N; i++) x_in[i*W +: W] = xv[i];
    eps = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_accept", 64'(busy), 64'd1);
    cycles = 0;
    do begin
      if (cycles == pulse_at) begin
        start = 1'b1;
        x_in = {$urandom, $urandom, $urandom, $urandom};
        eps = EPS_W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end while (!done && cycles < BOUND);
    start = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic [W-1:0] xv [N],
                             input logic [EPS_W-1:0] e, input res_t exp, input int pulse_at);
    int cyc;
    applyStimulus(xv, e, pulse_at, cyc);
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(exp.iter) + 64'd1);
    checkOutput({tag, "_valid"}, 64'(winner_valid), 64'(exp.valid));
    checkOutput({tag, "_timeout"}, 64'(timeout), 64'(exp.tmo));
    checkOutput({tag, "_idx"}, 64'(winner_idx), 64'(exp.idx));
    checkOutput({tag, "_val"}, 64'(winner_val), 64'(exp.val));
    checkOutput({tag, "_iter"}, 64'(iter_count), 64'(exp.iter));
    @(negedge clk);
    checkOutput({tag, "_busy_fall"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
    checkOutput({tag, "_hold_val"}, 64'(winner_val), 64'(exp.val));
  endtask

  logic [W-1:0] v_single [N];
  logic [W-1:0] v_one    [N];
  logic [W-1:0] v_tie    [N];
  logic [W-1:0] v_tmo    [N];
  logic [W-1:0] v_rnd    [N];
  res_t exp_single, exp_one, exp_tie, exp_tmo, exp_rnd;

  initial begin
    int cyc;
    logic [EPS_W-1:0] e_rnd;

    v_single = '{32'd0, 32'd0, 32'd0, 32'd77};
    v_one    = '{32'd100, 32'd0, 32'd0, 32'd200};
    v_tie    = '{32'd50, 32'd50, 32'd0, 32'd0};
    v_tmo    = '{32'd5, 32'd6, 32'd0, 32'd0};
    exp_single = '{valid: 1'b1, tmo: 1'b0, idx: 2'd3, val: 32'd77,  iter: 8'd0};
    exp_one    = '{valid: 1'b1, tmo: 1'b0, idx: 2'd3, val: 32'd200, iter: 8'd1};
    exp_tie    = '{valid: 1'b0, tmo: 1'b0, idx: 2'd0, val: 32'd50,  iter: 8'd6};
    exp_tmo    = '{valid: 1'b0, tmo: 1'b1, idx: 2'd1, val: 32'd6,   iter: 8'd255};

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_results", {winner_valid, timeout, winner_idx, winner_val, iter_count}, 64'd0);
    rst_n = 1'b1;

    runAndCheck("single", v_single, 16'h2000, exp_single, -1);
    runAndCheck("onestep", v_one, 16'h8000, exp_one, -1);
    runAndCheck("tie", v_tie, 16'h8000, exp_tie, -1);
    runAndCheck("timeout", v_tmo, 16'h0000, exp_tmo, -1);
    runAndCheck("pulse_in_run", v_tie, 16'h8000, exp_tie, 2);

    // Start held high across a whole run: one done, then re-accept only from IDLE.
    @(negedge clk);
    for (int i = 0; i < N; i++) x_in[i*W +: W] = v_one[i];
    eps = 16'h8000;
    start = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < BOUND);
    checkOutput("held_done", 64'(done), 64'd1);
    checkOutput("held_latency", 64'(cyc), 64'd3);
    @(negedge clk);
    checkOutput("held_idle_gap", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("held_reaccept", 64'(busy), 64'd1);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < BOUND);
    checkOutput("held2_latency", 64'(cyc), 64'd2);
    checkOutput("held2_val", 64'(winner_val), 64'd200);

    // Reset in the middle of the tie run.
    @(negedge clk);
    for (int i = 0; i < N; i++) x_in[i*W +: W] = v_tie[i];
    eps = 16'h8000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrun_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_results", {winner_valid, timeout, winner_idx, winner_val, iter_count}, 64'd0);
    runAndCheck("after_reset", v_single, 16'h2000, exp_single, -1);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       v_rnd[i] = '0;
          1:       v_rnd[i] = W'($urandom_range(0, 255));
          2:       v_rnd[i] = W'($urandom_range(0, 65535));
          default: v_rnd[i] = $urandom;
        endcase
      end
      case ($urandom_range(0, 7))
        0:       e_rnd = '0;
        1, 2:    e_rnd = EPS_W'($urandom_range(1, 16'h3FFF));
        default: e_rnd = EPS_W'($urandom_range(16'h4000, 16'hFFFF));
      endcase
      model(v_rnd, e_rnd, exp_rnd);
      runAndCheck("random", v_rnd, e_rnd, exp_rnd, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxnet_engine.md
# maxnet_engine

Parametrised winner-take-all (Maxnet) engine: captures N unsigned activations, iterates the lateral-inhibition update a_i ← ReLU(a_i − ε·Σ_{j≠i} a_j) with all channels in parallel, and reports the index and original value of the surviving channel. It generalises the fixed 4-channel Maxnet datapath in these ways:

- Channel count, data width and ε precision are parameters.
- The control FSM is built in, with a start/done handshake.
- ε is supplied at run time.
- Ties and non-convergence are detected and reported.

It sits between the input-vector source and downstream consumers of the winner.

## Interface
- N, 4, channel count (≥2)
- W, 32, unsigned activation width
- EPS_W, 16, ε width; ε is unsigned Q0.EPS_W (value = eps/2^EPS_W)
- MAX_ITER, 255, maximum update iterations before timeout
- IW, 8, iteration counter width (must hold MAX_ITER)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE
- x_in  in  N*W  packed inputs, channel i at [i*W +: W]; sampled with start
- eps  in  EPS_W  inhibition weight; sampled with start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, results valid
- winner_valid  out  1  exactly one nonzero channel remained
- timeout  out  1  MAX_ITER reached without convergence
- winner_idx  out  clog2(N)  winning/reported channel
- winner_val  out  W  original x_in of winner_idx
- iter_count  out  IW  update iterations performed

## Operation
- Registers:
  - x_reg[N] holds the captured inputs.
  - a_reg[N] holds the working activations.
  - eps_reg holds the captured ε.
  - iter holds the update count.
- FSM states: IDLE, RUN, DONE.
  - IDLE: when start=1, load x_reg, a_reg, eps_reg from the inputs, clear iter, go to RUN. Otherwise hold.
  - RUN: each cycle, evaluate nz = the count of nonzero a_reg.
    - nz==1: go to DONE, winner_valid=1, winner_idx = that channel.
    - nz==0: go to DONE, winner_valid=0, winner_idx=0. This covers ties that annihilate and the all-zero input.
    - Otherwise, if iter==MAX_ITER: go to DONE, timeout=1, winner_valid=0, winner_idx = argmax a_reg (lowest index on equal values).
    - Otherwise: update all a_reg in parallel and increment iter.
  - DONE: done=1 for this single cycle, then go to IDLE.
- Termination checks take priority over the update. The nz==1 check applies before the first update, so a single-nonzero input needs 0 iterations.
- Arithmetic:
  - S = Σ a_reg, computed at W+clog2(N) bits.
  - Each channel computes r_i = S − a_i.
  - Each channel computes p_i = ceil(r_i·eps / 2^EPS_W). The full-width product is (W+clog2(N)+EPS_W) bits. Ceiling guarantees a decrement of ≥1 whenever eps>0 and r_i>0.
  - Result: a_i' = (p_i ≥ a_i) ? 0 : a_i − p_i. This is never negative and never exceeds a_i, so no overflow is possible.
- Result outputs (winner_*, timeout, iter_count) are registered on entry to DONE. They hold until the next accepted start, which clears them.
- start during RUN or DONE is ignored; no queuing.
- eps=0 with ≥2 nonzero inputs always times out.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all internal registers 0.
- rst_n=0 on any edge, including mid-RUN: the next state is IDLE with reset values. It takes priority over start.
- Accept: start=1 in IDLE at edge E0. busy=1 from E0 onward.
- A run with k update iterations:
  - RUN occupies k+1 cycles.
  - done and the results appear after edge E0+k+1.
  - busy falls after edge E0+k+2.
- Minimum latency start→done is 1 cycle (k=0).
- A new start is accepted in the cycle after done at the earliest.
- iter_count equals k; at timeout it equals MAX_ITER.

## Test plan
- Single nonzero: x={0,0,0,77}, eps=0x2000 → done 1 cycle after start, winner_valid=1, winner_idx=3, winner_val=77, iter_count=0.
- One-step convergence: x={100,0,0,200}, eps=0x8000 → after iteration 1, a={0,0,0,150}. Expect done 2 cycles after start, winner_idx=3, winner_val=200, iter_count=1, winner_valid=1.
- Tie annihilation: x={50,50,0,0}, eps=0x8000 → both channels follow 25,12,6,3,1,0. Expect done 7 cycles after start, winner_valid=0, winner_idx=0, iter_count=6, timeout=0.
- Timeout: x={5,6,0,0}, eps=0 → done after 256 RUN cycles, timeout=1, winner_valid=0, winner_idx=1, winner_val=6, iter_count=255.
- Handshake robustness:
  - start held high throughout a run → a second run begins only from IDLE; exactly one done per accepted start.
  - start pulsed during RUN → ignored; results unchanged.
- Reset mid-run: rst_n=0 for one cycle during the tie case at iteration 3 → next cycle busy=0, done=0, all outputs 0. A subsequent start with the single-nonzero vector completes normally.
